// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the parametrised streaming convolution.
// Sizing functions are evaluated at elaboration time from the block parameters.
package conv_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic int num_pass(input int f_size, input int p);
    return f_size / p;
  endfunction

  // Wide enough that a full F_SIZE-term dot product can never overflow.
  function automatic int acc_width(input int dw_x, input int dw_f, input int f_size);
    return dw_x + dw_f + $clog2(f_size);
  endfunction

  function automatic longint sat_hi(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_lo(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// P-wide signed multiply with summed products, purely combinational.
// Result is sign-extended to the internal accumulator width before summing.
module conv_mac_lane
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH_X = 8,
  parameter int DATA_WIDTH_F = 8,
  parameter int P            = 2,
  parameter int AW           = 18
) (
  input  logic [P-1:0][DATA_WIDTH_X-1:0] x,
  input  logic [P-1:0][DATA_WIDTH_F-1:0] f,
  output logic signed [AW-1:0]           sum
);

  logic signed [AW-1:0] x_ext;
  logic signed [AW-1:0] f_ext;

  always_comb begin
    sum   = '0;
    x_ext = '0;
    f_ext = '0;
    for (int i = 0; i < P; i++) begin
      x_ext = {{(AW-DATA_WIDTH_X){x[i][DATA_WIDTH_X-1]}}, x[i]};
      f_ext = {{(AW-DATA_WIDTH_F){f[i][DATA_WIDTH_F-1]}}, f[i]};
      sum   = sum + x_ext * f_ext;
    end
  end

endmodule

// File: rtl/conv_stream_par.sv
// Frame convolution y[k] = sum x[k+j]*f[j], P taps per cycle over F_SIZE/P passes,
// streamed one result at a time on a valid/ready port with optional saturation.
module conv_stream_par
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH_X = 8,
  parameter int DATA_WIDTH_F = 8,
  parameter int X_SIZE       = 16,
  parameter int F_SIZE       = 4,
  parameter int P            = 2,
  parameter int ACC_SIZE     = 18,
  parameter bit SATURATE     = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           s_valid_x,
  output logic                           s_ready_x,
  input  logic signed [DATA_WIDTH_X-1:0] s_data_in_x,
  input  logic                           s_valid_f,
  output logic                           s_ready_f,
  input  logic signed [DATA_WIDTH_F-1:0] s_data_in_f,
  input  logic                           keep_f,
  output logic                           m_valid_y,
  input  logic                           m_ready_y,
  output logic signed [ACC_SIZE-1:0]     m_data_out_y,
  output logic                           m_last_y,
  output logic                           m_sat_y,
  output logic                           busy
);

  localparam int NUM_PASS = num_pass(F_SIZE, P);
  localparam int AW       = acc_width(DATA_WIDTH_X, DATA_WIDTH_F, F_SIZE);
  localparam int XIW      = $clog2(X_SIZE);
  localparam int FIW      = $clog2(F_SIZE);
  localparam int XCW      = $clog2(X_SIZE + 1);
  localparam int FCW      = $clog2(F_SIZE + 1);
  localparam int PW       = $clog2(NUM_PASS + 1);
  localparam int K_LAST   = X_SIZE - F_SIZE;

  if (F_SIZE % P != 0) begin : g_bad_p
    $error("conv_stream_par: F_SIZE must be a multiple of P");
  end
  if (X_SIZE <= F_SIZE) begin : g_bad_x
    $error("conv_stream_par: X_SIZE must exceed F_SIZE");
  end

  state_t state, state_nxt;

  logic [DATA_WIDTH_X-1:0] x_mem [X_SIZE];
  logic [DATA_WIDTH_F-1:0] f_mem [F_SIZE];

  logic [XCW-1:0]       x_cnt;
  logic [FCW-1:0]       f_cnt;
  logic                 f_held;
  logic [XIW-1:0]       k;
  logic [PW-1:0]        p;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] lane_sum;
  logic signed [AW-1:0] acc_sum;
  logic [ACC_SIZE-1:0]  y_nar;
  logic                 sat_nar;

  logic [P-1:0][DATA_WIDTH_X-1:0] x_vec;
  logic [P-1:0][DATA_WIDTH_F-1:0] f_vec;

  logic x_full, f_full, x_wr, f_wr, last_pass, last_k, hs;

  // A held filter counts as full so the frame can start on X alone.
  assign x_full    = (x_cnt == XCW'(X_SIZE));
  assign f_full    = f_held || (f_cnt == FCW'(F_SIZE));
  assign s_ready_x = (state == LOAD) && !x_full;
  assign s_ready_f = (state == LOAD) && !f_full;
  assign x_wr      = s_valid_x && s_ready_x;
  assign f_wr      = s_valid_f && s_ready_f;
  assign last_pass = (p == PW'(NUM_PASS - 1));
  assign last_k    = (k == XIW'(K_LAST));
  assign m_valid_y = (state == OUTPUT);
  assign hs        = m_valid_y && m_ready_y;
  assign busy      = (state != LOAD);

  always_comb begin
    x_vec = '0;
    f_vec = '0;
    for (int i = 0; i < P; i++) begin
      x_vec[i] = x_mem[XIW'(int'(k) + int'(p) * P + i)];
      f_vec[i] = f_mem[FIW'(int'(p) * P + i)];
    end
  end

  conv_mac_lane #(
    .DATA_WIDTH_X (DATA_WIDTH_X),
    .DATA_WIDTH_F (DATA_WIDTH_F),
    .P            (P),
    .AW           (AW)
  ) u_lane (
    .x   (x_vec),
    .f   (f_vec),
    .sum (lane_sum)
  );

  assign acc_sum = acc + lane_sum;

  if (ACC_SIZE >= AW) begin : g_wide
    assign y_nar   = ACC_SIZE'(acc_sum);
    assign sat_nar = 1'b0;
  end else begin : g_narrow
    localparam longint HI = sat_hi(ACC_SIZE);
    localparam longint LO = sat_lo(ACC_SIZE);
    localparam logic [ACC_SIZE-1:0] HI_Y = ACC_SIZE'(HI);
    localparam logic [ACC_SIZE-1:0] LO_Y = ACC_SIZE'(LO);
    logic ovf_hi, ovf_lo;
    assign ovf_hi  = longint'(acc_sum) > HI;
    assign ovf_lo  = longint'(acc_sum) < LO;
    assign sat_nar = ovf_hi || ovf_lo;
    // Wrap mode simply keeps the low bits; the flag still reports the overflow.
    assign y_nar   = (SATURATE && ovf_hi) ? HI_Y :
                     (SATURATE && ovf_lo) ? LO_Y : acc_sum[ACC_SIZE-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (x_full && f_full) state_nxt = COMPUTE;
      COMPUTE: if (last_pass) state_nxt = OUTPUT;
      OUTPUT:  if (hs) state_nxt = last_k ? DONE : COMPUTE;
      DONE:    state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_cnt        <= '0;
      f_cnt        <= '0;
      f_held       <= 1'b0;
      k            <= '0;
      p            <= '0;
      acc          <= '0;
      m_data_out_y <= '0;
      m_last_y     <= 1'b0;
      m_sat_y      <= 1'b0;
    end else begin
      if (x_wr) x_cnt <= x_cnt + XCW'(1);
      if (f_wr) f_cnt <= f_cnt + FCW'(1);
      unique case (state)
        LOAD: begin
          if (x_full && f_full) begin
            acc <= '0;
            p   <= '0;
            k   <= '0;
          end
        end
        COMPUTE: begin
          acc <= acc_sum;
          p   <= p + PW'(1);
          if (last_pass) begin
            m_data_out_y <= y_nar;
            m_sat_y      <= sat_nar;
            m_last_y     <= last_k;
          end
        end
        OUTPUT: begin
          if (hs && !last_k) begin
            k   <= k + XIW'(1);
            p   <= '0;
            acc <= '0;
          end
        end
        DONE: begin
          x_cnt  <= '0;
          k      <= '0;
          f_held <= keep_f;
          if (!keep_f) f_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // Sample memories are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (x_wr) x_mem[x_cnt[XIW-1:0]] <= s_data_in_x;
    if (f_wr) f_mem[f_cnt[FIW-1:0]] <= s_data_in_f;
  end

endmodule

// File: tb/tb_conv_stream_par.sv
// Random-stimulus scoreboard bench: a saturating and a wrapping instance share inputs
// and are checked against a direct dot-product model of each frame.
module tb_conv_stream_par;

  localparam int XS = 8;
  localparam int FS = 4;
  localparam int AS = 16;

  logic clk = 1'b0;
  logic reset;
  logic s_valid_x, s_valid_f, keep_f, m_ready_y;
  logic signed [7:0] s_data_in_x, s_data_in_f;

  logic s_ready_x, s_ready_f, m_valid_y, m_last_y, m_sat_y, busy;
  logic signed [AS-1:0] m_data_out_y;
  logic s_ready_x_w, s_ready_f_w, m_valid_y_w, m_last_y_w, m_sat_y_w, busy_w;
  logic signed [AS-1:0] m_data_out_y_w;

  always #5 clk = ~clk;

  conv_stream_par #(.DATA_WIDTH_X(8), .DATA_WIDTH_F(8), .X_SIZE(XS), .F_SIZE(FS), .P(2),
                    .ACC_SIZE(AS), .SATURATE(1'b1)) dut (
    .clk(clk), .reset(reset),
    .s_valid_x(s_valid_x), .s_ready_x(s_ready_x), .s_data_in_x(s_data_in_x),
    .s_valid_f(s_valid_f), .s_ready_f(s_ready_f), .s_data_in_f(s_data_in_f),
    .keep_f(keep_f), .m_valid_y(m_valid_y), .m_ready_y(m_ready_y),
    .m_data_out_y(m_data_out_y), .m_last_y(m_last_y), .m_sat_y(m_sat_y), .busy(busy));

  conv_stream_par #(.DATA_WIDTH_X(8), .DATA_WIDTH_F(8), .X_SIZE(XS), .F_SIZE(FS), .P(2),
                    .ACC_SIZE(AS), .SATURATE(1'b0)) dut_w (
    .clk(clk), .reset(reset),
    .s_valid_x(s_valid_x), .s_ready_x(s_ready_x_w), .s_data_in_x(s_data_in_x),
    .s_valid_f(s_valid_f), .s_ready_f(s_ready_f_w), .s_data_in_f(s_data_in_f),
    .keep_f(keep_f), .m_valid_y(m_valid_y_w), .m_ready_y(m_ready_y),
    .m_data_out_y(m_data_out_y_w), .m_last_y(m_last_y_w), .m_sat_y(m_sat_y_w), .busy(busy_w));

  typedef struct {
    longint raw;
    bit     last;
  } exp_t;

  exp_t   q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc = 0;
  int     tb_x[XS];
  int     tb_f[FS];
  int     cur_f[FS];
  int     last_wr_cyc = 0;
  bit     first_pending = 1'b0;
  bit     stall_en = 1'b0;
  int     stall_cnt = 0;
  bit     holding = 1'b0;
  logic signed [AS-1:0] held;
  int     out_idx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  localparam longint HI = (longint'(1) <<< (AS - 1)) - 1;
  localparam longint LO = -(longint'(1) <<< (AS - 1));

  function automatic longint clamp_ref(input longint v);
    return (v > HI) ? HI : (v < LO) ? LO : v;
  endfunction

  function automatic longint wrap_ref(input longint v);
    longint m = longint'(1) <<< AS;
    return ((((v - LO) % m) + m) % m) + LO;
  endfunction

  function automatic longint oob_ref(input longint v);
    return (v > HI || v < LO) ? 1 : 0;
  endfunction

  // Output monitor: owns m_ready_y, pops the scoreboard on every handshake.
  initial begin
    exp_t e;
    m_ready_y = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        holding = 1'b0;
        m_ready_y = 1'b0;
      end else if (m_valid_y) begin
        if (first_pending) begin
          chk("first_latency", longint'(cyc - last_wr_cyc), 3);
          first_pending = 1'b0;
        end
        if (holding) chk("stall_hold", longint'(m_data_out_y), longint'(held));
        if (stall_en && out_idx == 1 && stall_cnt < 10) begin
          m_ready_y = 1'b0;
          stall_cnt++;
        end else begin
          m_ready_y = ($urandom_range(0, 3) != 0);
        end
        if (m_ready_y) begin
          holding = 1'b0;
          if (q.size() == 0) begin
            fail_now("extra_output");
          end else begin
            e = q.pop_front();
            chk("y_sat",      longint'(m_data_out_y),   clamp_ref(e.raw));
            chk("flag_sat",   longint'(m_sat_y),        oob_ref(e.raw));
            chk("last_sat",   longint'(m_last_y),       longint'(e.last));
            chk("valid_wrap", longint'(m_valid_y_w),    1);
            chk("y_wrap",     longint'(m_data_out_y_w), wrap_ref(e.raw));
            chk("flag_wrap",  longint'(m_sat_y_w),      oob_ref(e.raw));
            chk("last_wrap",  longint'(m_last_y_w),     longint'(e.last));
            out_idx = e.last ? 0 : out_idx + 1;
          end
        end else begin
          held = m_data_out_y;
          holding = 1'b1;
        end
      end else begin
        holding = 1'b0;
        m_ready_y = 1'(($urandom_range(0, 1)));
      end
    end
  end

  task automatic load_frame(input bit load_f, input bit gaps, input bit push);
    int xi = 0;
    int fi = 0;
    int guard = 0;
    bit fx, ff;
    longint raw;
    if (load_f) cur_f = tb_f;
    if (push) begin
      for (int k = 0; k <= XS - FS; k++) begin
        raw = 0;
        for (int j = 0; j < FS; j++) raw += longint'(tb_x[k + j]) * longint'(cur_f[j]);
        q.push_back('{raw, k == XS - FS});
      end
    end
    @(negedge clk);
    if (!load_f) chk("f_ready_held", longint'(s_ready_f), 0);
    while ((xi < XS || (load_f && fi < FS)) && guard < 1000) begin
      s_valid_x = 1'b0;
      s_valid_f = 1'b0;
      if (xi < XS) begin
        s_valid_x = !gaps || ($urandom_range(0, 2) != 0);
        s_data_in_x = 8'(tb_x[xi]);
      end else if (gaps) begin
        s_valid_x = 1'b1;
        s_data_in_x = 8'sh55;
      end
      if (load_f && fi < FS) begin
        s_valid_f = !gaps || ($urandom_range(0, 2) != 0);
        s_data_in_f = 8'(tb_f[fi]);
      end else if (load_f && gaps) begin
        s_valid_f = 1'b1;
        s_data_in_f = 8'sh33;
      end
      fx = s_valid_x && s_ready_x;
      ff = s_valid_f && s_ready_f;
      if (fx) xi++;
      if (ff) fi++;
      if (fx || ff) last_wr_cyc = cyc + 1;
      @(negedge clk);
      guard++;
    end
    s_valid_x = 1'b0;
    s_valid_f = 1'b0;
    if (guard >= 1000) fail_now("load_timeout");
    first_pending = push;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((q.size() != 0 || busy || m_valid_y) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) begin
      fail_now("idle_timeout");
      q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready_x"}, longint'(s_ready_x), 1);
    chk({tag, "_ready_f"}, longint'(s_ready_f), 1);
    chk({tag, "_valid"},   longint'(m_valid_y), 0);
    chk({tag, "_data"},    longint'(m_data_out_y), 0);
    chk({tag, "_last"},    longint'(m_last_y), 0);
    chk({tag, "_sat"},     longint'(m_sat_y), 0);
    chk({tag, "_busy"},    longint'(busy), 0);
    chk({tag, "_valid_w"}, longint'(m_valid_y_w), 0);
  endtask

  initial begin
    bit kept = 1'b0;
    bit kf;
    int guard;
    reset = 1'b0;
    s_valid_x = 1'b0;
    s_valid_f = 1'b0;
    s_data_in_x = '0;
    s_data_in_f = '0;
    keep_f = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;

    for (int i = 0; i < XS; i++) tb_x[i] = i + 1;
    for (int j = 0; j < FS; j++) tb_f[j] = 1;
    load_frame(1'b1, 1'b0, 1'b1);
    wait_idle();

    tb_f[0] = 1; tb_f[1] = -1; tb_f[2] = 0; tb_f[3] = 2;
    load_frame(1'b1, 1'b1, 1'b1);
    wait_idle();

    for (int i = 0; i < XS; i++) tb_x[i] = 127;
    for (int j = 0; j < FS; j++) tb_f[j] = 127;
    load_frame(1'b1, 1'b0, 1'b1);
    wait_idle();

    // Backpressure on the second output, gapped inputs, and filter retention.
    for (int i = 0; i < XS; i++) tb_x[i] = i + 1;
    for (int j = 0; j < FS; j++) tb_f[j] = 1;
    stall_cnt = 0;
    stall_en = 1'b1;
    keep_f = 1'b1;
    load_frame(1'b1, 1'b1, 1'b1);
    wait_idle();
    stall_en = 1'b0;
    chk("stall_len", longint'(stall_cnt), 10);
    keep_f = 1'b0;

    for (int i = 0; i < XS; i++) tb_x[i] = i + 2;
    load_frame(1'b0, 1'b1, 1'b1);
    wait_idle();

    for (int it = 0; it < 6; it++) begin
      kf = (it < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      for (int i = 0; i < XS; i++) tb_x[i] = int'($urandom_range(0, 255)) - 128;
      for (int j = 0; j < FS; j++) tb_f[j] = int'($urandom_range(0, 255)) - 128;
      keep_f = kf;
      load_frame(!kept, 1'($urandom_range(0, 1)), 1'b1);
      wait_idle();
      kept = kf;
    end
    keep_f = 1'b0;

    // Abort a frame mid-COMPUTE, then run a clean frame.
    for (int i = 0; i < XS; i++) tb_x[i] = int'($urandom_range(0, 255)) - 128;
    for (int j = 0; j < FS; j++) tb_f[j] = int'($urandom_range(0, 255)) - 128;
    load_frame(1'b1, 1'b0, 1'b0);
    guard = 0;
    while (!busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) fail_now("busy_timeout");
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    q.delete();
    first_pending = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < XS; i++) tb_x[i] = int'($urandom_range(0, 255)) - 128;
    for (int j = 0; j < FS; j++) tb_f[j] = int'($urandom_range(0, 255)) - 128;
    load_frame(1'b1, 1'b1, 1'b1);
    wait_idle();

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
